// File: rtl/eq_pkg.sv
// Shared definitions for the histogram-equalization sequencer.
// Contents:
//   DEF_PIX_W, DEF_IMG_W_LOG2 : default pixel width and log2 of the image side
//   DEF_L, DEF_BIN_W          : derived level count and histogram/CDF width
//   state_t                   : sequencer states
//   map_level()               : CDF-to-output-level mapping (truncating, no cdf_min term)
// Optional feature macro used by the design files: HIST_READBACK_EN
package eq_pkg;

  localparam int DEF_PIX_W      = 3;
  localparam int DEF_IMG_W_LOG2 = 8;
  localparam int DEF_L          = 1 << DEF_PIX_W;
  localparam int DEF_BIN_W      = 2 * DEF_IMG_W_LOG2 + 1;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    COUNT,
    CDF,
    MAP,
    DONE
  } state_t;

  // new = (cdf * (L-1)) >> (2*IMG_W_LOG2). The result never exceeds L-1
  // because cdf is at most N = 2^(2*IMG_W_LOG2). The caller narrows the
  // 32-bit result to its pixel width.
  function automatic logic [31:0] map_level(input logic [31:0] cdf,
                                            input int pixW,
                                            input int imgLog2);
    logic [31:0] prod;
    prod = cdf * ((32'd1 << pixW) - 32'd1);
    return prod >> (2 * imgLog2);
  endfunction

endpackage

// File: rtl/hist_eq_ctrl_hist_bank.sv
// hist_bank: L histogram bins with synchronous clear, increment-by-index
// and an indexed combinational read.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset (bins -> 0)
//   clr_i           : zero every bin on the next edge
//   inc_i/inc_idx_i : add one to bin inc_idx_i on the next edge
//   rd_idx_i        : read index, rd_data_o = bin[rd_idx_i]
//   rb_idx_i        : second read index for display readback (HIST_READBACK_EN)
//   rb_data_o       : bin[rb_idx_i] (HIST_READBACK_EN)
// Macro: HIST_READBACK_EN adds the second read port.
module hist_bank
  import eq_pkg::*;
#(
  parameter int PIX_W = DEF_PIX_W,
  parameter int BIN_W = DEF_BIN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [PIX_W-1:0] inc_idx_i,
  input  logic [PIX_W-1:0] rd_idx_i,
  output logic [BIN_W-1:0] rd_data_o
`ifdef HIST_READBACK_EN
  ,
  input  logic [PIX_W-1:0] rb_idx_i,
  output logic [BIN_W-1:0] rb_data_o
`endif
);

  localparam int L = 1 << PIX_W;

  logic [BIN_W-1:0] bins_q [L];

  // Clear has priority over increment; the sequencer never asserts both.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < L; i++) bins_q[i] <= '0;
    end else if (clr_i) begin
      for (int i = 0; i < L; i++) bins_q[i] <= '0;
    end else if (inc_i) begin
      bins_q[inc_idx_i] <= bins_q[inc_idx_i] + BIN_W'(1);
    end
  end

  assign rd_data_o = bins_q[rd_idx_i];

`ifdef HIST_READBACK_EN
  assign rb_data_o = bins_q[rb_idx_i];
`endif

endmodule

// File: rtl/hist_eq_ctrl.sv
// hist_eq_ctrl: sequencer for histogram equalization of a square image.
// A start request runs CLEAR -> COUNT (histogram pass) -> CDF -> MAP
// (remap pass writing the destination image) -> DONE.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   start_i           : one-cycle run request, only honoured in IDLE
//   busy_o            : high from CLEAR through the end of MAP
//   done_o            : one-cycle pulse when the destination image is complete
//   src_addr_o        : source read address (row-major)
//   src_rd_en_o       : source read strobe
//   src_data_i        : source pixel, valid one cycle after src_rd_en_o
//   dst_addr_o        : destination write address
//   dst_we_o          : destination write enable
//   dst_data_o        : equalized pixel
//   hist_rd_idx_i     : histogram readback index (HIST_READBACK_EN)
//   hist_rd_data_o    : histogram bin value (HIST_READBACK_EN)
// Macro: HIST_READBACK_EN adds the histogram readback ports.
module hist_eq_ctrl
  import eq_pkg::*;
#(
  parameter int IMG_W_LOG2 = DEF_IMG_W_LOG2,
  parameter int PIX_W      = DEF_PIX_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [2*IMG_W_LOG2-1:0] src_addr_o,
  output logic                    src_rd_en_o,
  input  logic [PIX_W-1:0]        src_data_i,
  output logic [2*IMG_W_LOG2-1:0] dst_addr_o,
  output logic                    dst_we_o,
  output logic [PIX_W-1:0]        dst_data_o
`ifdef HIST_READBACK_EN
  ,
  input  logic [PIX_W-1:0]        hist_rd_idx_i,
  output logic [2*IMG_W_LOG2:0]   hist_rd_data_o
`endif
);

  localparam int AW    = 2 * IMG_W_LOG2;
  localparam int L     = 1 << PIX_W;
  localparam int BIN_W = AW + 1;
  localparam int N     = 1 << AW;

  localparam logic [AW:0]      CNT_LAST = (AW + 1)'(N);
  localparam logic [PIX_W-1:0] BIN_LAST = PIX_W'(L - 1);

  state_t state_q, state_d;

  logic [AW:0]        cnt_q;
  logic [AW-1:0]      addrDly_q;
  logic               valid_q;
  logic [PIX_W-1:0]   binIdx_q;
  logic [BIN_W-1:0]   cdf_q [L];

  logic               rdEn;
  logic [BIN_W-1:0]   histRd;
  logic [BIN_W-1:0]   cdfPrev;
  logic [BIN_W-1:0]   cdfSum;
  logic [PIX_W-1:0]   mapped;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic. Both passes end on the drain cycle (cnt_q == N),
  // which exists only to consume the read issued for address N-1.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start_i) state_d = CLEAR;
      CLEAR: state_d = COUNT;
      COUNT: if (cnt_q == CNT_LAST) state_d = CDF;
      CDF:   if (binIdx_q == BIN_LAST) state_d = MAP;
      MAP:   if (cnt_q == CNT_LAST) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The extra counter bit marks the drain cycle, so reads stop at N-1 and
  // the low bits are already back at 0 for the next pass.
  assign rdEn = ((state_q == COUNT) || (state_q == MAP)) && !cnt_q[AW];

  // Pass counter, read-valid pipeline and CDF bin counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      addrDly_q <= '0;
      valid_q   <= 1'b0;
      binIdx_q  <= '0;
    end else begin
      if ((state_q == COUNT) || (state_q == MAP)) begin
        cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + (AW + 1)'(1);
      end else begin
        cnt_q <= '0;
      end
      valid_q <= rdEn;
      if (rdEn) addrDly_q <= cnt_q[AW-1:0];
      if (state_q == CDF) binIdx_q <= binIdx_q + PIX_W'(1);
      else                binIdx_q <= '0;
    end
  end

  hist_bank #(
    .PIX_W (PIX_W),
    .BIN_W (BIN_W)
  ) u_hist_bank (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (state_q == CLEAR),
    .inc_i     ((state_q == COUNT) && valid_q),
    .inc_idx_i (src_data_i),
    .rd_idx_i  (binIdx_q),
    .rd_data_o (histRd)
`ifdef HIST_READBACK_EN
    ,
    .rb_idx_i  (hist_rd_idx_i),
    .rb_data_o (hist_rd_data_o)
`endif
  );

  // Running sum for the bin currently being accumulated.
  always_comb begin
    cdfPrev = '0;
    if (binIdx_q != '0) cdfPrev = cdf_q[binIdx_q - PIX_W'(1)];
    cdfSum = cdfPrev + histRd;
  end

  // CDF registers hold their values after DONE until the next CLEAR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < L; i++) cdf_q[i] <= '0;
    end else if (state_q == CLEAR) begin
      for (int i = 0; i < L; i++) cdf_q[i] <= '0;
    end else if (state_q == CDF) begin
      cdf_q[binIdx_q] <= cdfSum;
    end
  end

  assign mapped = PIX_W'(map_level(32'(cdf_q[src_data_i]), PIX_W, IMG_W_LOG2));

  // Outputs decode from state so reset forces them to zero immediately.
  assign busy_o      = (state_q == CLEAR) || (state_q == COUNT) ||
                       (state_q == CDF)   || (state_q == MAP);
  assign done_o      = (state_q == DONE);
  assign src_rd_en_o = rdEn;
  assign src_addr_o  = rdEn ? cnt_q[AW-1:0] : '0;
  assign dst_we_o    = (state_q == MAP) && valid_q;
  assign dst_addr_o  = dst_we_o ? addrDly_q : '0;
  assign dst_data_o  = dst_we_o ? mapped : '0;

endmodule

// File: tb/tb_hist_eq_ctrl.sv
// Testbench for hist_eq_ctrl at IMG_W_LOG2=2 (N=16), PIX_W=3 (L=8).
// A 1-cycle-latency source memory feeds the DUT; a reference model computes
// the histogram, CDF and expected destination image from the source contents.
// Macro: HIST_READBACK_EN enables the histogram readback checks.
module tb_hist_eq_ctrl;

  localparam int IMG_W_LOG2 = 2;
  localparam int PIX_W      = 3;
  localparam int AW         = 2 * IMG_W_LOG2;
  localparam int N          = 1 << AW;
  localparam int L          = 1 << PIX_W;
  localparam int RUN_CYCLES = 2 * N + L + 3;

  logic            clk;
  logic            rst;
  logic            start;
  logic            busy;
  logic            done;
  logic [AW-1:0]   src_addr;
  logic            src_rd_en;
  logic [PIX_W-1:0] src_data;
  logic [AW-1:0]   dst_addr;
  logic            dst_we;
  logic [PIX_W-1:0] dst_data;
`ifdef HIST_READBACK_EN
  logic [PIX_W-1:0] hist_rd_idx;
  logic [AW:0]      hist_rd_data;
`endif

  logic [PIX_W-1:0] srcMem [N];
  logic [PIX_W-1:0] dstLog [N];
  int modelHist [L];
  int modelCdf  [L];
  int expOut    [N];

  int passCount  = 0;
  int checkCount = 0;
  int readIdx    = 0;
  int writeIdx   = 0;
  int doneCount  = 0;

  hist_eq_ctrl #(
    .IMG_W_LOG2 (IMG_W_LOG2),
    .PIX_W      (PIX_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start),
    .busy_o      (busy),
    .done_o      (done),
    .src_addr_o  (src_addr),
    .src_rd_en_o (src_rd_en),
    .src_data_i  (src_data),
    .dst_addr_o  (dst_addr),
    .dst_we_o    (dst_we),
    .dst_data_o  (dst_data)
`ifdef HIST_READBACK_EN
    ,
    .hist_rd_idx_i  (hist_rd_idx),
    .hist_rd_data_o (hist_rd_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source image memory with one cycle of read latency.
  always @(posedge clk) begin
    if (src_rd_en) src_data <= srcMem[src_addr];
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Reference model: histogram, cumulative sum, then per-pixel remap.
  task automatic computeModel();
    int run;
    for (int v = 0; v < L; v++) modelHist[v] = 0;
    for (int a = 0; a < N; a++) modelHist[int'(srcMem[a])]++;
    run = 0;
    for (int v = 0; v < L; v++) begin
      run += modelHist[v];
      modelCdf[v] = run;
    end
    for (int a = 0; a < N; a++)
      expOut[a] = (modelCdf[int'(srcMem[a])] * (L - 1)) / N;
  endtask

  task automatic loadPattern(input int pattern);
    for (int a = 0; a < N; a++) begin
      case (pattern)
        0:       srcMem[a] = PIX_W'(3);
        1:       srcMem[a] = PIX_W'(a % L);
        default: srcMem[a] = (a < 8) ? PIX_W'(0) : PIX_W'(7);
      endcase
      dstLog[a] = '0;
    end
    computeModel();
    readIdx   = 0;
    writeIdx  = 0;
    doneCount = 0;
  endtask

  // Every cycle: reads must walk 0..N-1 twice, writes must come in address
  // order after their pass-two read, carrying the model's remapped value.
  always @(negedge clk) begin
    if (src_rd_en) begin
      checkOutput("src_addr", 64'(src_addr), 64'(readIdx % N));
      readIdx++;
    end
    if (dst_we) begin
      checkOutput("write_after_read", 64'(readIdx >= N + writeIdx + 1), 64'(1));
      checkOutput("dst_addr", 64'(dst_addr), 64'(writeIdx));
      checkOutput("dst_data", 64'(dst_data), 64'(expOut[int'(dst_addr)]));
      dstLog[dst_addr] = dst_data;
      writeIdx++;
    end
    if (done) doneCount++;
  end

  task automatic applyStimulus(input int pattern, input bit extraStart);
    int busyCycles;
    loadPattern(pattern);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    busyCycles = 0;
    while (busy && busyCycles < 200) begin
      busyCycles++;
      start = extraStart && (busyCycles == 10);
      @(negedge clk);
    end
    start = 1'b0;
    checkOutput("busy_cycles", 64'(busyCycles), 64'(RUN_CYCLES));
    checkOutput("done_after_busy", 64'(done), 64'(1));
    @(negedge clk);
    checkOutput("done_width", 64'(done), 64'(0));
    repeat (60) @(negedge clk);
    checkOutput("idle_after_run", 64'(busy), 64'(0));
    checkOutput("done_count", 64'(doneCount), 64'(1));
    checkOutput("read_count", 64'(readIdx), 64'(2 * N));
    checkOutput("write_count", 64'(writeIdx), 64'(N));
  endtask

  initial begin
    int waitCycles;
    rst   = 1'b1;
    start = 1'b0;
`ifdef HIST_READBACK_EN
    hist_rd_idx = '0;
`endif
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", 64'(busy), 64'(0));
    checkOutput("rst_done", 64'(done), 64'(0));
    checkOutput("rst_src_rd_en", 64'(src_rd_en), 64'(0));
    checkOutput("rst_src_addr", 64'(src_addr), 64'(0));
    checkOutput("rst_dst_we", 64'(dst_we), 64'(0));
    checkOutput("rst_dst_addr", 64'(dst_addr), 64'(0));
    checkOutput("rst_dst_data", 64'(dst_data), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // Constant image of 3: every pixel maps to 7.
    applyStimulus(0, 1'b0);
    checkOutput("const3_dst0", 64'(dstLog[0]), 64'(7));
    checkOutput("const3_dst15", 64'(dstLog[15]), 64'(7));
`ifdef HIST_READBACK_EN
    hist_rd_idx = 3'd3;
    #1 checkOutput("rb_bin3", 64'(hist_rd_data), 64'(16));
    hist_rd_idx = 3'd0;
    #1 checkOutput("rb_bin0", 64'(hist_rd_data), 64'(0));
`endif

    // Pixel = addr[2:0]: flat histogram, identity mapping. A second start
    // while busy must be ignored.
    applyStimulus(1, 1'b1);
    for (int v = 0; v < L; v++)
      checkOutput("ramp_identity", 64'(dstLog[v]), 64'(v));
`ifdef HIST_READBACK_EN
    for (int v = 0; v < L; v++) begin
      hist_rd_idx = PIX_W'(v);
      #1 checkOutput("rb_flat_bin", 64'(hist_rd_data), 64'(2));
    end
`endif

    // Half 0, half 7: 0 -> 3, 7 -> 7.
    applyStimulus(2, 1'b0);
    checkOutput("split_dst0", 64'(dstLog[0]), 64'(3));
    checkOutput("split_dst15", 64'(dstLog[15]), 64'(7));

    // Abort during the histogram pass at address 5.
    loadPattern(0);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    waitCycles = 0;
    while (!(src_rd_en && src_addr == 4'd5) && waitCycles < 100) begin
      waitCycles++;
      @(negedge clk);
    end
    checkOutput("abort_reached_addr5", 64'(waitCycles < 100), 64'(1));
    rst = 1'b1;
    #1;
    checkOutput("abort_busy", 64'(busy), 64'(0));
    checkOutput("abort_dst_we", 64'(dst_we), 64'(0));
    checkOutput("abort_src_rd_en", 64'(src_rd_en), 64'(0));
`ifdef HIST_READBACK_EN
    for (int v = 0; v < L; v++) begin
      hist_rd_idx = PIX_W'(v);
      #1 checkOutput("abort_bin_zero", 64'(hist_rd_data), 64'(0));
    end
`endif
    @(negedge clk) rst = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("abort_no_done", 64'(doneCount), 64'(0));

    // A normal run after the abort.
    applyStimulus(1, 1'b0);
    for (int v = 0; v < L; v++)
      checkOutput("post_abort_identity", 64'(dstLog[v + 8]), 64'(v));

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/hist_eq_ctrl.md
Name: hist_eq_ctrl

Overview:
Sequencer for the histogram-equalization datapath feeding the VGA side-by-side display. On a start request it reads the source image memory (the "old" image) to build an 8-bin histogram, accumulates the CDF, then makes a second pass that writes the remapped pixel into the destination image memory (the "new" image). Sits between the image RAM/ROMs and the VGA paint stage. `done` tells the display logic that the equalized image is valid.

Parameters:
IMG_W_LOG2, 8, log2 of image side; image is square, N = 2^(2*IMG_W_LOG2) pixels (default 65536).
PIX_W, 3, pixel code width; L = 2^PIX_W levels (default 8).

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
start  in  1  single-cycle request to run one equalization
busy  out  1  high while the run is in progress
done  out  1  one-cycle pulse when the destination image is complete
src_addr  out  2*IMG_W_LOG2  source read address, row-major (y*W + x)
src_rd_en  out  1  source read strobe
src_data  in  PIX_W  source pixel; valid exactly 1 cycle after src_rd_en
dst_addr  out  2*IMG_W_LOG2  destination write address
dst_we  out  1  destination write enable
dst_data  out  PIX_W  equalized pixel
hist_rd_idx  in  PIX_W  histogram readback index (only with HIST_READBACK_EN)
hist_rd_data  out  2*IMG_W_LOG2+1  histogram bin value (only with HIST_READBACK_EN)

Behaviour:
- Interface: one clock `clk`; `rst` is asynchronous and active-high.
- Reset: state = IDLE, all histogram bins and CDF registers = 0, and busy, done, src_rd_en, dst_we, src_addr, dst_addr, dst_data = 0.
- Widths: bins and CDF are 2*IMG_W_LOG2+1 bits, so a full-image single value (N) fits. The product cdf*(L-1) is 2*IMG_W_LOG2+1+PIX_W bits.
- Mapping: new = (cdf[v]*(L-1)) >> (2*IMG_W_LOG2). This is truncating, with no cdf_min term. The result is always <= L-1.
- IDLE: start=1 moves to CLEAR. start in any other state is ignored.
- CLEAR (1 cycle): zero all bins.
- COUNT (N+1 cycles):
  - Cycles 0..N-1 issue src_rd_en=1 with src_addr = 0..N-1.
  - A registered valid, delayed 1 cycle, increments hist[src_data]. The final cycle is the drain.
- CDF (L cycles): cdf[i] = cdf[i-1] + hist[i], one bin per cycle, with cdf[0] = hist[0].
- MAP (N+1 cycles):
  - Reissue reads for addresses 0..N-1.
  - One cycle later, dst_we=1, dst_addr = the delayed address, dst_data = map(src_data).
  - The final cycle is the drain.
- DONE (1 cycle): done=1, busy=0, then return to IDLE.
- busy is high for exactly 2N+L+3 cycles, starting in the cycle after start is sampled.
- src_rd_en and dst_we are never high outside COUNT and MAP. dst_we is never high during COUNT.
- The address counter wraps from N-1 to 0 between passes, and no read is issued beyond N-1.
- rst mid-run: immediate return to IDLE with all registers cleared. No done pulse is produced. The partial destination image is invalid.
- hist and CDF values hold after DONE until the next CLEAR.

Optional Feature:
HIST_READBACK_EN:
- Defined: hist_rd_data = hist[hist_rd_idx], combinational from the bin registers, for on-screen histogram bars.
- Undefined: both readback ports are absent.

Decomposition:
- Package eq_pkg holds:
  - PIX_W and IMG_W_LOG2 defaults, plus derived L and BIN_W.
  - State enum {IDLE, CLEAR, COUNT, CDF, MAP, DONE}.
  - The map function.
- One sub-module, hist_bank: L bins with clear, increment-by-index, and indexed read. The FSM, address counter, CDF and mapping stay in hist_eq_ctrl.

Test Plan (IMG_W_LOG2=2, N=16, PIX_W=3, source model with 1-cycle read latency):
- All pixels = 3, pulse start:
  - Required: hist[3]=16, other bins 0.
  - Required: cdf[0..2]=0, cdf[3..7]=16.
  - Required: 16 writes of dst_data=7 at addresses 0..15.
- Pixel = addr[2:0]:
  - Required: every bin = 2.
  - Required: dst_data equals the source value for v=0..7, i.e. map 0,1,2,3,4,5,6,7.
- Addresses 0..7 = 0 and 8..15 = 7:
  - Required: cdf[0]=8.
  - Required: writes 0 -> 3 and 7 -> 7.
- Timing:
  - Required: busy is high for exactly 2*16+8+3 = 43 cycles, then done is high for 1 cycle.
  - Required: a second start asserted while busy produces no extra run or done.
- Reset mid-run:
  - Stimulus: assert rst during COUNT at addr 5.
  - Required: busy=0, dst_we=0 and all bins = 0 with no clock edge.
  - Required: a following start completes normally.
- HIST_READBACK_EN defined, after the constant-3 run:
  - Required: hist_rd_idx=3 gives 16.
  - Required: hist_rd_idx=0 gives 0.
